// File: rtl/dmem_responder.sv
// Data-memory responder: slave side of the core load/store port.
// Takes one request at a time, waits WAIT_CYCLES, then performs the access
// on a little-endian array of XLEN-bit words and returns extended load data
// or an access-fault flag through a response handshake.
module dmem_responder #(
  parameter int              XLEN        = 64,
  parameter int              DEPTH       = 1024,
  parameter logic [XLEN-1:0] BASE        = 64'h80000000,
  parameter int              WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_wr,
  input  logic [2:0]      req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int              NBYTES = XLEN / 8;
  localparam int              IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] LIMIT  = BASE + XLEN'(8 * DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              wr_q;
  logic [2:0]        op_q;
  logic [3:0]        cnt_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic [XLEN-1:0]   mem [DEPTH];

  logic [2:0]        lane;
  logic [IDXW-1:0]   idx;
  logic              misaligned;
  logic              outOfRange;
  logic              illegalOp;
  logic              err_d;
  logic [NBYTES-1:0] sizeMask;
  logic [NBYTES-1:0] byteMask;
  logic [XLEN-1:0]   wdataShift;
  logic [XLEN-1:0]   word;
  logic [XLEN-1:0]   wordShift;
  logic [XLEN-1:0]   loadData;
  logic [XLEN-1:0]   rdata_d;
  logic              execute;

  // Decode the registered request: fault checks, lane masks and load extension
  always_comb begin
    lane       = addr_q[2:0];
    idx        = IDXW'((addr_q - BASE) >> 3);
    illegalOp  = (op_q == 3'b111);
    outOfRange = (addr_q < BASE) || (addr_q >= LIMIT);
    misaligned = 1'b0;
    case (op_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      2'b11:   misaligned = |addr_q[2:0];
      default: misaligned = 1'b0;
    endcase
    err_d = illegalOp || outOfRange || misaligned;

    // U variants share the size of their signed counterparts on stores
    case (op_q[1:0])
      2'b00:   sizeMask = NBYTES'(8'h01);
      2'b01:   sizeMask = NBYTES'(8'h03);
      2'b10:   sizeMask = NBYTES'(8'h0F);
      default: sizeMask = NBYTES'(8'hFF);
    endcase
    byteMask   = sizeMask << lane;
    wdataShift = wdata_q << {lane, 3'b000};

    word      = mem[idx];
    wordShift = word >> {lane, 3'b000};
    case (op_q)
      3'b000:  loadData = {{(XLEN-8){wordShift[7]}}, wordShift[7:0]};
      3'b001:  loadData = {{(XLEN-16){wordShift[15]}}, wordShift[15:0]};
      3'b010:  loadData = {{(XLEN-32){wordShift[31]}}, wordShift[31:0]};
      3'b100:  loadData = {{(XLEN-8){1'b0}}, wordShift[7:0]};
      3'b101:  loadData = {{(XLEN-16){1'b0}}, wordShift[15:0]};
      3'b110:  loadData = {{(XLEN-32){1'b0}}, wordShift[31:0]};
      default: loadData = wordShift;
    endcase
    rdata_d = (wr_q || err_d) ? '0 : loadData;

    execute = (state_q == ACCESS) && (cnt_q == 4'(WAIT_CYCLES));
  end

  // Commit masked store bytes on the edge that leaves ACCESS; contents are never reset
  always_ff @(posedge clk) begin
    if (execute && wr_q && !err_d) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (byteMask[b]) begin
          mem[idx][8*b +: 8] <= wdataShift[8*b +: 8];
        end
      end
    end
  end

  // Request/response FSM: capture in IDLE, count wait states, hold response until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      op_q    <= 3'b000;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            op_q    <= req_op;
            cnt_q   <= 4'd0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (execute) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's load/store interface (address, write data, write enable, MemOp).
- Accepts one request at a time through a valid/ready handshake.
- Serves the request from an internal little-endian 64-bit-word array after a programmable number of wait states.
- Returns sign- or zero-extended load data, or an error flag, through a response handshake.
- Used as the data memory behind the core and as the bus-latency model for simulation.

Parameters:
- XLEN, 64, data and address width.
- DEPTH, 1024, number of 64-bit words in the array.
- BASE, 64'h80000000, byte address of word 0.
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_wr  in  1  1 = store, 0 = load.
- req_op  in  3  MemOp: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  XLEN  load result after extension; 0 for stores and errors.
- rsp_err  out  1  access fault (misaligned, out of range, or illegal op).

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Array contents are not reset.
- A reset that arrives mid-operation discards the pending request. An uncommitted store never reaches the array.
- State IDLE:
  - req_ready=1.
  - When req_valid is 1, the request is accepted on that edge: addr, wdata, wr, op are registered, counter is cleared, and the state moves to ACCESS.
- State ACCESS:
  - req_ready=0.
  - The counter increments each cycle.
  - When counter==WAIT_CYCLES, the access executes on that edge and the state moves to RESP.
  - With WAIT_CYCLES=0, ACCESS lasts exactly one cycle.
- State RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err are held stable.
  - When rsp_ready is 1, the state moves to IDLE on that edge and rsp_valid drops.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: at most one request per WAIT_CYCLES+3 cycles when rsp_ready is held at 1.
- Error checks, evaluated on the registered request:
  - Misaligned: H/HU needs addr[0]=0, W/WU needs addr[1:0]=0, D needs addr[2:0]=0.
  - Out of range: addr<BASE or addr>=BASE+8*DEPTH.
  - Illegal op: op=111.
  - Any error gives rsp_err=1 and rsp_rdata=0; the array is unchanged.
- Word index = (addr-BASE)>>3. Byte lane = addr[2:0].
- Store:
  - Byte mask by size: B 0x01, H 0x03, W 0x0F, D 0xFF, shifted left by the lane.
  - wdata is shifted left by 8*lane.
  - Only masked bytes are written, committed on the ACCESS->RESP edge.
  - The U variants of op on a store are treated as the same size as their signed counterparts.
  - rsp_rdata=0.
- Load:
  - The word is shifted right by 8*lane and truncated to the access size.
  - B, H, W are sign-extended to XLEN. BU, HU, WU are zero-extended. D passes through.
- Inputs are ignored outside IDLE; changes to req_* during ACCESS/RESP have no effect.
- Held request: if req_valid stays 1 through the response handshake, it is re-accepted as a new request in the following IDLE cycle.
- Read-after-write: a load issued after a store's response returns the stored data.

Test Plan:
- Store D 0x1122334455667788 at 0x80000010, then load D from 0x80000010 -> rsp_rdata=0x1122334455667788, rsp_err=0, rsp_valid high exactly 3 cycles after acceptance (WAIT_CYCLES=2).
- Store B 0xF0 at 0x80000013, then load B from 0x80000013 -> 0xFFFFFFFFFFFFFFF0. Load BU from the same address -> 0xF0. Load D from 0x80000010 -> 0x11223344F0667788.
- Load H from 0x80000011 -> rsp_err=1, rsp_rdata=0. Store W to 0x7FFFFFF8 -> rsp_err=1 and the array is unchanged. Request with op=111 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata remain stable, req_ready=0, and a new req_valid is not accepted. Raise rsp_ready -> IDLE on the next cycle.
- Pull rst_n low during ACCESS of a store of 0xAAAA to 0x80000020 -> all outputs return to reset values immediately. A subsequent load of 0x80000020 returns the pre-store value.
- Set WAIT_CYCLES=0 and issue back-to-back loads with rsp_ready=1 -> each response arrives 1 cycle after acceptance, and acceptances occur every 3 cycles.
